uart_tx_core: RTL and testbench
===============================

// Module: uart_tx_core
// PURPOSE
//  Serial UART transmitter; the companion of the receive-side shift register and framing logic.
//  Accepts one parallel character per valid/ready handshake and emits one frame on tx_out:
//  start bit (0), then data bits LSB first, then one stop bit (1).
//  Feeds the APB UART TX path; bit timing comes from a programmable bit period.
// PARAMETERS
//  BP_W    14   width of bit_period (clocks per serial bit)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst         in   1      asynchronous, active-high reset
//  tx_valid    in   1      character available on tx_data
//  tx_ready    out  1      block can accept a character (high only in IDLE)
//  tx_data     in   8      character, right-justified; bits above data_size ignored
//  data_size   in   4      5, 7 or 8 data bits; any other value = 8
//  bit_period  in   BP_W   clocks per bit; values 0 and 1 treated as 2
//  tx_out      out  1      serial line, idle high
//  tx_busy     out  1      frame in progress (START, DATA or STOP)
//  tx_done     out  1      one-cycle pulse: frame complete
// BEHAVIOUR
//  Reset (async, immediate) values:
//   tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE.
//   All counters and shift register are cleared.
//  FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
//  Accept: tx_valid & tx_ready at rising edge k.
//   At accept, latch tx_data, eff_size (5/7/8) and eff_period = max(bit_period, 2).
//   Later input changes do not affect the frame in flight.
//   tx_valid while busy is ignored; nothing is queued.
//  Timing, all outputs registered:
//   START: entered at edge k. tx_out=0 from cycle k+1 for eff_period cycles.
//   DATA: eff_size bits, each held eff_period cycles. Bit i = latched tx_data[i], i=0 first.
//   STOP: tx_out=1 for eff_period cycles.
//   Frame length is exactly (eff_size+2)*eff_period cycles after the accept edge.
//  Counters:
//   Bit-timer counts 0..eff_period-1 and advances the bit on terminal count.
//   Bit counter counts 0..eff_size-1 in DATA. Sized so no wrap occurs at BP_W max (16383).
//  Completion: at the end of STOP, go to IDLE.
//   In that first IDLE cycle: tx_done=1, tx_ready=1, tx_busy=0, tx_out=1.
//   An accept in that same cycle is legal; the next start bit begins one cycle later.
//   Minimum idle gap between frames is therefore 1 clock.
//  tx_busy = (state != IDLE). tx_ready = ~tx_busy.
//  tx_done is never high outside the first IDLE cycle after STOP.
//  Reset mid-frame: line returns high immediately, frame aborted, tx_done not pulsed.
// TESTING
//  1 Reset, then check idle outputs: tx_out=1, tx_ready=1, tx_busy=0, tx_done=0.
//  2 Send 0xA5, size 8, P=4. Expect tx_out sequence 0,1,0,1,0,0,1,0,1,1,
//    each bit held 4 clocks; tx_done pulses 40 clocks after accept.
//  3 Send 0x3F, size 5, P=3. Expect 0,1,1,1,1,1,1; upper bits are not sent;
//    frame is 21 clocks.
//  4 Send 0x55, size 7, P=2. Expect 0,1,0,1,0,1,0,1,1.
//  5 Change tx_data and bit_period mid-frame, and hold tx_valid high while busy.
//    Expect the frame unchanged and no second accept until tx_done.
//  6 Send back-to-back with tx_valid held high (0x01 then 0x80, size 8, P=2).
//    Expect one idle-high clock between frames, then the second frame intact.
//  7 With bit_period=0, expect 2-clock bits.
//  8 Assert rst during DATA. Expect tx_out=1 asynchronously and no tx_done;
//    after rst drops, a new accept produces a clean frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Character handshake and serial-line bundle between a UART TX client and uart_tx_core.
interface uart_tx_if #(
  parameter int BP_W = 14
);
  logic            tx_valid;
  logic            tx_ready;
  logic [7:0]      tx_data;
  logic [3:0]      data_size;
  logic [BP_W-1:0] bit_period;
  logic            tx_out;
  logic            tx_busy;
  logic            tx_done;

  modport master (
    output tx_valid, tx_data, data_size, bit_period,
    input  tx_ready, tx_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_valid, tx_data, data_size, bit_period,
    output tx_ready, tx_out, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 5/7/8 data bits LSB first, one stop bit, programmable bit period.
//  state   | meaning
//  S_IDLE  | line high, ready for a character
//  S_START | driving the start bit (0)
//  S_DATA  | shifting data bits out LSB first
//  S_STOP  | driving the stop bit (1)
module uart_tx_core #(
  parameter int BP_W = 14
) (
  input  logic    clk,
  input  logic    rst,
  uart_tx_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]      state;
  logic [BP_W-1:0] period_q;
  logic [BP_W-1:0] bit_tmr;
  logic [3:0]      size_q;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            tx_out_q;
  logic            done_q;

  logic [3:0]      eff_size;
  logic [BP_W-1:0] eff_period;
  logic            tmr_tc;
  logic            accept;

  always_comb begin
    case (bus.data_size)
      4'd5:    eff_size = 4'd5;
      4'd7:    eff_size = 4'd7;
      default: eff_size = 4'd8;
    endcase
    eff_period = (bus.bit_period < BP_W'(2)) ? BP_W'(2) : bus.bit_period;
    tmr_tc     = (bit_tmr == period_q - BP_W'(1));
    accept     = bus.tx_valid && (state == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      period_q <= '0;
      bit_tmr  <= '0;
      size_q   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_START;
            shreg    <= bus.tx_data;
            size_q   <= eff_size;
            period_q <= eff_period;
            bit_tmr  <= '0;
            bit_cnt  <= '0;
            tx_out_q <= 1'b0;
          end
        end
        S_START: begin
          if (tmr_tc) begin
            state    <= S_DATA;
            bit_tmr  <= '0;
            bit_cnt  <= '0;
            tx_out_q <= shreg[0];
            shreg    <= shreg >> 1;
          end else begin
            bit_tmr <= bit_tmr + BP_W'(1);
          end
        end
        S_DATA: begin
          if (tmr_tc) begin
            bit_tmr <= '0;
            if (bit_cnt == size_q - 4'd1) begin
              state    <= S_STOP;
              tx_out_q <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              tx_out_q <= shreg[0];
              shreg    <= shreg >> 1;
            end
          end else begin
            bit_tmr <= bit_tmr + BP_W'(1);
          end
        end
        S_STOP: begin
          if (tmr_tc) begin
            state    <= S_IDLE;
            bit_tmr  <= '0;
            done_q   <= 1'b1;
            tx_out_q <= 1'b1;
          end else begin
            bit_tmr <= bit_tmr + BP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_out   = tx_out_q;
  assign bus.tx_busy  = (state != S_IDLE);
  assign bus.tx_ready = (state == S_IDLE);
  assign bus.tx_done  = done_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed frames plus random frames against a frame model.
module tb_uart_tx_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.BP_W(14)) bus ();

  uart_tx_core #(.BP_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check_val({tag, "_out"},   32'(bus.tx_out),   32'd1);
      check_val({tag, "_busy"},  32'(bus.tx_busy),  32'd0);
      check_val({tag, "_ready"}, 32'(bus.tx_ready), 32'd1);
      check_val({tag, "_done"},  32'(bus.tx_done),  32'd0);
    end
  endtask

  // Called at a negedge. Accepts one character and checks every cycle of the frame
  // against the frame shape derived from the latched character, size and period.
  task automatic run_frame(input logic [7:0] d, input logic [3:0] sz, input logic [13:0] per,
                           input bit keep_valid, input bit perturb);
    int n, p, len, f;
    logic e;
    n   = (sz == 4'd5) ? 5 : (sz == 4'd7) ? 7 : 8;
    p   = (per < 14'd2) ? 2 : int'(per);
    len = (n + 2) * p;
    bus.tx_data    = d;
    bus.data_size  = sz;
    bus.bit_period = per;
    bus.tx_valid   = 1'b1;
    check_val("ready_at_accept", 32'(bus.tx_ready), 32'd1);
    @(posedge clk);
    for (int j = 0; j <= len; j++) begin
      @(negedge clk);
      if (j == 0 && !keep_valid && !perturb) bus.tx_valid = 1'b0;
      if (perturb && j == 2) begin
        bus.tx_data    = ~d;
        bus.bit_period = per + 14'd3;
        bus.data_size  = (sz == 4'd5) ? 4'd8 : 4'd5;
      end
      if (j == len && !keep_valid) bus.tx_valid = 1'b0;
      if (j < len) begin
        f = j / p;
        if (f == 0)      e = 1'b0;
        else if (f <= n) e = d[f-1];
        else             e = 1'b1;
        check_val("frame_out",   32'(bus.tx_out),   32'(e));
        check_val("frame_busy",  32'(bus.tx_busy),  32'd1);
        check_val("frame_ready", 32'(bus.tx_ready), 32'd0);
        check_val("frame_done",  32'(bus.tx_done),  32'd0);
      end else begin
        check_val("end_out",   32'(bus.tx_out),   32'd1);
        check_val("end_busy",  32'(bus.tx_busy),  32'd0);
        check_val("end_ready", 32'(bus.tx_ready), 32'd1);
        check_val("end_done",  32'(bus.tx_done),  32'd1);
      end
    end
  endtask

  // Aborts a frame of all-zero data with reset while a data bit is on the line.
  task automatic abort_frame();
    bus.tx_data    = 8'h00;
    bus.data_size  = 4'd8;
    bus.bit_period = 14'd3;
    bus.tx_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_val("abort_pre_out",  32'(bus.tx_out),  32'd0);
    check_val("abort_pre_busy", 32'(bus.tx_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_val("abort_out",   32'(bus.tx_out),   32'd1);
    check_val("abort_busy",  32'(bus.tx_busy),  32'd0);
    check_val("abort_ready", 32'(bus.tx_ready), 32'd1);
    check_val("abort_done",  32'(bus.tx_done),  32'd0);
    repeat (3) begin
      @(negedge clk);
      check_val("abort_hold_done", 32'(bus.tx_done), 32'd0);
    end
    rst = 1'b0;
    check_idle("post_abort", 2);
  endtask

  initial begin
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.data_size  = 4'd8;
    bus.bit_period = 14'd4;
    repeat (2) @(negedge clk);
    check_val("rst_out",   32'(bus.tx_out),   32'd1);
    check_val("rst_ready", 32'(bus.tx_ready), 32'd1);
    check_val("rst_busy",  32'(bus.tx_busy),  32'd0);
    check_val("rst_done",  32'(bus.tx_done),  32'd0);
    rst = 1'b0;
    check_idle("idle_after_rst", 2);

    run_frame(8'hA5, 4'd8, 14'd4, 1'b0, 1'b0);
    check_idle("gap_a5", 2);
    run_frame(8'h3F, 4'd5, 14'd3, 1'b0, 1'b0);
    check_idle("gap_3f", 2);
    run_frame(8'h55, 4'd7, 14'd2, 1'b0, 1'b0);
    check_idle("gap_55", 2);
    run_frame(8'hC3, 4'd8, 14'd3, 1'b0, 1'b1);
    check_idle("gap_perturb", 2);
    run_frame(8'h01, 4'd8, 14'd2, 1'b1, 1'b0);
    run_frame(8'h80, 4'd8, 14'd2, 1'b0, 1'b0);
    check_idle("gap_b2b", 2);
    run_frame(8'h96, 4'd8, 14'd0, 1'b0, 1'b0);
    check_idle("gap_p0", 1);
    run_frame(8'h69, 4'd3, 14'd1, 1'b0, 1'b0);
    check_idle("gap_p1", 1);

    abort_frame();
    run_frame(8'h5A, 4'd8, 14'd3, 1'b0, 1'b0);
    check_idle("gap_after_abort", 1);

    for (int r = 0; r < 24; r++) begin
      logic [7:0]  rd;
      logic [3:0]  rs;
      logic [13:0] rp;
      rd = 8'($urandom);
      rs = 4'($urandom_range(0, 15));
      rp = 14'($urandom_range(0, 5));
      run_frame(rd, rs, rp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bus.tx_valid = 1'b0;
    check_idle("final", 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
